// File: rtl/stream_mux_rr_pkg.sv
//------------------------------------------------------------------------------
// Module : stream_mux_rr_pkg
// Brief  : Shared constants and helpers for the stream_mux_rr channel merger.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package stream_mux_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for `value` entries; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stream_mux_rr_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Combinational rotating-priority arbiter; first request at or above
//          ptr wins, otherwise the lowest request overall (wrap).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
   import stream_mux_rr_pkg::*;
#(
   parameter int N = 8,
   localparam int SW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic          gnt_valid,
   output logic [SW-1:0] gnt_idx
);

   // Descending scans so the final assignment is the lowest matching index;
   // the second pass overrides with the lowest request at or above ptr.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SW'(i);
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i] && (SW'(i) >= ptr)) gnt_idx = SW'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/stream_mux_rr.sv
//------------------------------------------------------------------------------
// Module : stream_mux_rr
// Brief  : N-channel valid/ready stream merger with registered output and
//          fixed-select or round-robin arbitration. Define MUX_PKT_LOCK_EN to
//          hold the grant on one channel until its last beat.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_mux_rr
   import stream_mux_rr_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 8,
   localparam int SW = clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_last,
   output logic [N-1:0]   in_ready,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic           out_last,
   output logic [SW-1:0]  out_ch,
   input  logic           out_ready
);

   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q,  out_data_d;
   logic          out_last_q,  out_last_d;
   logic [SW-1:0] out_ch_q,    out_ch_d;
   logic [SW-1:0] rr_ptr_q,    rr_ptr_d;

   logic          arb_valid;
   logic [SW-1:0] arb_idx;
   logic          gnt_valid;
   logic [SW-1:0] gnt_idx;
   logic          can_accept;
   logic [N-1:0]  ready_vec;
   logic [W-1:0]  gnt_data;
   logic          gnt_last;
   logic          xfer;
   logic          ptr_adv_ok;

`ifdef MUX_PKT_LOCK_EN
   logic          lock_q,    lock_d;
   logic [SW-1:0] lock_ch_q, lock_ch_d;
`endif

   rr_arbiter #(.N(N)) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .gnt_valid (arb_valid),
      .gnt_idx   (arb_idx)
   );

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      if (mode == MODE_RR) begin
         gnt_valid = arb_valid;
         gnt_idx   = arb_idx;
      end else if (int'(sel) < N) begin
         gnt_valid = 1'b1;
         gnt_idx   = sel;
      end
`ifdef MUX_PKT_LOCK_EN
      if (lock_q) begin
         gnt_valid = 1'b1;
         gnt_idx   = lock_ch_q;
      end
`endif
   end

   assign can_accept = !out_valid_q || out_ready;

   always_comb begin
      ready_vec = '0;
      gnt_data  = '0;
      gnt_last  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == SW'(i)) begin
            ready_vec[i] = gnt_valid && can_accept && !rst;
            gnt_data     = in_data[i*W +: W];
            gnt_last     = in_last[i];
         end
      end
   end

   assign in_ready = ready_vec;
   assign xfer     = |(ready_vec & in_valid);

`ifdef MUX_PKT_LOCK_EN
   assign ptr_adv_ok = gnt_last;
`else
   assign ptr_adv_ok = 1'b1;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      rr_ptr_d    = rr_ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         out_last_d  = gnt_last;
         out_ch_d    = gnt_idx;
         // Wrap at N, not 2^SW, so unused indices are never pointed at.
         if ((mode == MODE_RR) && ptr_adv_ok)
            rr_ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef MUX_PKT_LOCK_EN
   always_comb begin
      lock_d    = lock_q;
      lock_ch_d = lock_ch_q;
      if (xfer) begin
         lock_d    = !gnt_last;
         lock_ch_d = gnt_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_ch_q <= lock_ch_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
//------------------------------------------------------------------------------
// Module : tb_stream_mux_rr
// Brief  : Directed self-checking bench for stream_mux_rr (N=8 and N=5).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst;

   logic        mode8;
   logic [2:0]  sel8;
   logic [7:0]  valid8;
   logic [63:0] data8;
   logic [7:0]  last8;
   logic [7:0]  ready8;
   logic        ovalid8;
   logic [7:0]  odata8;
   logic        olast8;
   logic [2:0]  och8;
   logic        oready8;

   logic        mode5;
   logic [2:0]  sel5;
   logic [4:0]  valid5;
   logic [39:0] data5;
   logic [4:0]  last5;
   logic [4:0]  ready5;
   logic        ovalid5;
   logic [7:0]  odata5;
   logic        olast5;
   logic [2:0]  och5;
   logic        oready5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.N(8), .W(8)) dut8 (
      .clk(clk), .rst(rst), .mode(mode8), .sel(sel8),
      .in_valid(valid8), .in_data(data8), .in_last(last8), .in_ready(ready8),
      .out_valid(ovalid8), .out_data(odata8), .out_last(olast8), .out_ch(och8),
      .out_ready(oready8)
   );

   stream_mux_rr #(.N(5), .W(8)) dut5 (
      .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
      .in_valid(valid5), .in_data(data5), .in_last(last5), .in_ready(ready5),
      .out_valid(ovalid5), .out_data(odata5), .out_last(olast5), .out_ch(och5),
      .out_ready(oready5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst     = 1'b1;
      mode8   = 1'b0;
      sel8    = 3'd5;
      valid8  = 8'hFF;
      last8   = 8'h00;
      oready8 = 1'b1;
      for (int i = 0; i < 8; i++) data8[i*8 +: 8] = 8'(8'h10 + i);
      mode5   = 1'b1;
      sel5    = 3'd0;
      valid5  = 5'b0;
      last5   = 5'b0;
      oready5 = 1'b1;
      for (int i = 0; i < 5; i++) data5[i*8 +: 8] = 8'(8'h50 + i);

      // Reset held two cycles with every channel requesting.
      tick();
      chk("rst1_out_valid", 32'(ovalid8), 32'd0);
      chk("rst1_in_ready",  32'(ready8),  32'd0);
      chk("rst1_out_data",  32'(odata8),  32'd0);
      tick();
      chk("rst2_out_valid", 32'(ovalid8), 32'd0);
      chk("rst2_in_ready",  32'(ready8),  32'd0);
      chk("rst2_out_ch",    32'(och8),    32'd0);
      chk("rst2_n5_valid",  32'(ovalid5), 32'd0);
      rst = 1'b0;
      data8[5*8 +: 8] = 8'hA5;
      #1;
      chk("fixed_in_ready", 32'(ready8), 32'h20);
      tick();
      chk("fixed_out_valid", 32'(ovalid8), 32'd1);
      chk("fixed_out_data",  32'(odata8),  32'hA5);
      chk("fixed_out_ch",    32'(och8),    32'd5);

      // Round-robin, all channels valid: pointer still 0 after fixed mode.
      mode8 = 1'b1;
      data8[5*8 +: 8] = 8'h15;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rr_out_ch",    32'(och8),    32'(i % 8));
         chk("rr_out_data",  32'(odata8),  32'(8'h10 + (i % 8)));
         chk("rr_out_valid", 32'(ovalid8), 32'd1);
      end

      // Load 0x3C from ch1, then stall the consumer.
      data8[1*8 +: 8] = 8'h3C;
      tick();
      chk("bp_load_data", 32'(odata8), 32'h3C);
      chk("bp_load_ch",   32'(och8),   32'd1);
      oready8 = 1'b0;
      #1;
      chk("bp_in_ready_now", 32'(ready8), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_hold_data",  32'(odata8),  32'h3C);
         chk("bp_hold_valid", 32'(ovalid8), 32'd1);
         chk("bp_in_ready",   32'(ready8),  32'd0);
      end
      oready8 = 1'b1;
      #1;
      chk("bp_release_ready", 32'(ready8), 32'h04);
      tick();
      chk("bp_next_data", 32'(odata8), 32'h12);
      chk("bp_next_ch",   32'(och8),   32'd2);

      valid8 = 8'h00;
      #1;
      chk("idle_in_ready", 32'(ready8), 32'd0);
      tick();
      chk("drain_valid", 32'(ovalid8), 32'd0);
      chk("drain_data_hold", 32'(odata8), 32'h12);

      // Packet from ch2 (3 beats) competing with ch3; pointer is at 3.
      valid8 = 8'h04;
      tick();
      chk("pkt_a_ch",   32'(och8),   32'd2);
      chk("pkt_a_last", 32'(olast8), 32'd0);
      valid8 = 8'h0C;
      tick();
`ifdef MUX_PKT_LOCK_EN
      chk("pkt_b_ch", 32'(och8), 32'd2);
`else
      chk("pkt_b_ch", 32'(och8), 32'd3);
`endif
      last8[2] = 1'b1;
      tick();
      chk("pkt_c_ch",   32'(och8),   32'd2);
      chk("pkt_c_last", 32'(olast8), 32'd1);
      last8[2] = 1'b0;
      tick();
      chk("pkt_d_ch",   32'(och8),   32'd3);
      chk("pkt_d_last", 32'(olast8), 32'd0);
      valid8 = 8'h00;

      // N=5: push pointer to 4 via ch3, then ch4 and ch0 compete.
      valid5 = 5'b01000;
      tick();
      chk("n5_ch3", 32'(och5), 32'd3);
      valid5 = 5'b10001;
      #1;
      chk("n5_ready_ch4", 32'(ready5), 32'b10000);
      tick();
      chk("n5_ch4",   32'(och5),   32'd4);
      chk("n5_data4", 32'(odata5), 32'h54);
      #1;
      chk("n5_ready_ch0", 32'(ready5), 32'b00001);
      tick();
      chk("n5_wrap_ch0", 32'(och5),   32'd0);
      chk("n5_data0",    32'(odata5), 32'h50);
      valid5 = 5'b0;
      mode5  = 1'b0;
      sel5   = 3'd6;
      #1;
      chk("n5_sel_oob_ready", 32'(ready5), 32'd0);
      sel5 = 3'd4;
      #1;
      chk("n5_sel4_ready", 32'(ready5), 32'b10000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
